fir_mac_sched: RTL and testbench

Time-multiplexing scheduler that runs a TAPS-tap FIR on one shared `MAC` instance. It owns the coefficient bank and the circular sample delay line. For each accepted input sample it issues TAPS operand pairs to the MAC, one per cycle, and accumulates the returned rounded products. It then presents the filter output on a valid/ready stream. It sits between the sample source and the filter output consumer, and replaces a TAPS-long systolic MAC chain where throughput allows.

---
 rtl/fir_mac_sched.sv | 117 +++++++++++
 tb/tb_fir_mac_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sched.sv
// fir_mac_sched: runs a TAPS-tap FIR on one shared pipelined MAC.
// Each accepted sample is written into a circular delay line, then TAPS
// (coef, sample) pairs are issued one per cycle. A tag shift register tracks
// which MAC output slots carry real products; those are summed into acc and
// presented on a valid/ready output stream.
module fir_mac_sched #(
  parameter int TAPS    = 16,
  parameter int B_WIDTH = 12,
  parameter int COEFF_W = 16,
  parameter int C_WIDTH = 12,
  parameter int MAC_LAT = 4,
  parameter int ACC_W   = C_WIDTH + 1 + $clog2(TAPS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [COEFF_W-1:0]      coef_wdata,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [B_WIDTH-1:0]      s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [ACC_W-1:0]        m_data,
  output logic                    busy,
  output logic [COEFF_W-1:0]      mac_coeff,
  output logic [B_WIDTH-1:0]      mac_b,
  output logic [C_WIDTH-1:0]      mac_c,
  input  logic [C_WIDTH:0]        mac_p
);
  localparam int AW = $clog2(TAPS);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;
  localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);
  // Tag pattern in the cycle the final product is on mac_p during DRAIN.
  localparam logic [MAC_LAT-1:0] TAG_LAST = MAC_LAT'(1) << (MAC_LAT - 1);

  logic [1:0]         state;
  logic [COEFF_W-1:0] coef [TAPS];
  logic [B_WIDTH-1:0] xbuf [TAPS];
  logic [AW-1:0]      wp, np, k, rd_idx;
  logic [MAC_LAT-1:0] tag;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   p_ext;
  logic               accept;

  assign s_ready = reset && (state == S_IDLE);
  assign accept  = s_valid && s_ready;
  assign busy    = (state != S_IDLE);
  assign m_valid = (state == S_OUT);
  assign m_data  = acc;
  assign mac_c   = '0;
  assign p_ext   = {{(ACC_W-C_WIDTH-1){mac_p[C_WIDTH]}}, mac_p};

  // Oldest-ward tap index (np - k) mod TAPS; also correct for non-power-of-2 TAPS.
  assign rd_idx    = (np >= k) ? (np - k) : (np + AW'(TAPS) - k);
  assign mac_coeff = (state == S_ISSUE) ? coef[k] : '0;
  assign mac_b     = (state == S_ISSUE) ? xbuf[rd_idx] : '0;

  // Sequencer: accept -> issue TAPS taps -> wait for MAC pipe -> present result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      wp    <= '0;
      np    <= '0;
      k     <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          np    <= wp;
          wp    <= (wp == K_LAST) ? '0 : wp + 1'b1;
          k     <= '0;
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          k <= k + 1'b1;
          if (k == K_LAST) state <= S_DRAIN;
        end
        S_DRAIN: if (tag == TAG_LAST) state <= S_OUT;
        default: if (m_ready) state <= S_IDLE;
      endcase
    end
  end

  // Tag pipe mirrors MAC latency; only tagged slots are accumulated.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag <= '0;
      acc <= '0;
    end else begin
      tag <= (tag << 1) | MAC_LAT'(state == S_ISSUE);
      if (accept)              acc <= '0;
      else if (tag[MAC_LAT-1]) acc <= acc + p_ext;
    end
  end

  // Coefficient bank: writes land only while idle, otherwise dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) coef[i] <= '0;
    end else if (coef_we && !busy) begin
      coef[coef_addr] <= coef_wdata;
    end
  end

  // Circular delay line: newest sample written at wp.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) xbuf[i] <= '0;
    end else if (accept) begin
      xbuf[wp] <= s_data;
    end
  end

endmodule

// File: tb/tb_fir_mac_sched.sv
// Testbench for fir_mac_sched: external MAC model, reference FIR over a
// sample history queue, and a decoupled output scoreboard.
module tb_fir_mac_sched;
  localparam int TAPS  = 16;
  localparam int BW    = 12;
  localparam int CW    = 16;
  localparam int PW    = 12;
  localparam int L     = 4;
  localparam int AW    = 4;
  localparam int ACC_W = PW + 1 + AW;

  logic              clock = 0;
  logic              reset = 0;
  logic              coef_we = 0;
  logic [AW-1:0]     coef_addr = '0;
  logic [CW-1:0]     coef_wdata = '0;
  logic              s_valid = 0;
  logic              s_ready;
  logic [BW-1:0]     s_data = '0;
  logic              m_valid;
  logic              m_ready = 1;
  logic [ACC_W-1:0]  m_data;
  logic              busy;
  logic [CW-1:0]     mac_coeff;
  logic [BW-1:0]     mac_b;
  logic [PW-1:0]     mac_c;
  logic [PW:0]       mac_p;

  fir_mac_sched #(.TAPS(TAPS), .B_WIDTH(BW), .COEFF_W(CW), .C_WIDTH(PW), .MAC_LAT(L)) dut (
    .clock(clock), .reset(reset), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy),
    .mac_coeff(mac_coeff), .mac_b(mac_b), .mac_c(mac_c), .mac_p(mac_p)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // MAC: Q12 product with round-half-up, result truncated to PW+1 bits.
  function automatic logic signed [PW:0] mac_fn(input logic signed [CW-1:0] c,
                                                input logic signed [BW-1:0] b);
    longint p;
    p = longint'(c) * longint'(b);
    p = (p + 2048) >>> 12;
    return p[PW:0];
  endfunction

  logic [PW:0] mpipe [L];
  always @(posedge clock) begin
    for (int i = L-1; i > 0; i--) mpipe[i] <= mpipe[i-1];
    mpipe[0] <= mac_fn(mac_coeff, mac_b);
  end
  assign mac_p = mpipe[L-1];

  typedef struct { logic [ACC_W-1:0] data; int cyc; } exp_t;
  exp_t                  exp_q [$];
  logic signed [BW-1:0]  hist [$];
  logic signed [CW-1:0]  cm [TAPS];
  bit                    we_applies = 0;
  bit                    front_seen = 0;
  bit                    rnd_ready = 0;
  int                    n_acc = 0;
  int                    tests = 0;
  int                    fails = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: on accept, y = sum over k of MAC(coef[k], x[n-k]), x < 0 => 0.
  always @(negedge clock) begin
    if (reset) begin
      if (coef_we && we_applies) cm[coef_addr] = coef_wdata;
      if (s_valid && s_ready) begin
        longint y;
        exp_t e;
        hist.push_back(s_data);
        if (hist.size() > TAPS) void'(hist.pop_front());
        y = 0;
        for (int j = 0; j < TAPS; j++) begin
          int idx;
          idx = hist.size() - 1 - j;
          if (idx >= 0) y = y + mac_fn(cm[j], hist[idx]);
        end
        e.data = ACC_W'(y);
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
        n_acc++;
      end
    end
  end

  // Output monitor: data, stability under stall, latency, no input accept in OUT.
  always @(negedge clock) begin
    if (reset && m_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_m_valid", 1, 0);
      end else begin
        if (!front_seen) begin
          chk("latency", cyc - exp_q[0].cyc, TAPS + L);
          front_seen = 1;
        end
        chk("m_data", m_data, exp_q[0].data);
        chk("s_ready_in_out", s_ready, 0);
        if (m_ready) begin
          void'(exp_q.pop_front());
          front_seen = 0;
        end
      end
    end
  end

  initial forever begin
    @(posedge clock); #2;
    if (rnd_ready) m_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wcoef(input int a, input int d, input bit applies);
    coef_we = 1; coef_addr = AW'(a); coef_wdata = CW'(d); we_applies = applies;
    @(posedge clock); #1;
    coef_we = 0; we_applies = 0;
  endtask

  task automatic send(input int x);
    bit got;
    got = 0;
    s_data = BW'(x); s_valid = 1;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clock);
      if (s_ready) got = 1;
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clock); #1;
    s_valid = 0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) begin
      @(posedge clock); #1;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < TAPS; i++) cm[i] = 0;
    repeat (6) @(posedge clock); #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mac_coeff", mac_coeff, 0);
    chk("rst_mac_b", mac_b, 0);
    chk("rst_mac_c", mac_c, 0);
    reset = 1;
    @(posedge clock); #1;
    chk("rel_s_ready", s_ready, 1);

    // Impulse through a 1,2,3,4 repeating coefficient pattern.
    for (int j = 0; j < TAPS; j++) wcoef(j, (j % 4 + 1) * 'h1000, 1);
    send(100);
    for (int j = 0; j < 19; j++) send(0);
    wait_drain();

    // Unity step: ramps to 16x then holds.
    for (int j = 0; j < TAPS; j++) wcoef(j, 'h1000, 1);
    for (int j = 0; j < 20; j++) send(10);
    wait_drain();

    // Coefficient write during ISSUE is dropped; in IDLE it takes effect.
    send(10);
    wcoef(0, 'h7000, 0);
    wait_drain();
    wcoef(0, 'h7000, 1);
    send(10);
    wait_drain();
    // Write coincident with accept is used by that sample.
    coef_we = 1; coef_addr = '0; coef_wdata = 16'h1000; we_applies = 1;
    send(-5);
    coef_we = 0; we_applies = 0;
    wait_drain();

    // Back-pressure: input held valid while output is stalled.
    begin
      int n0;
      bit got;
      n0 = n_acc;
      got = 0;
      m_ready = 0;
      s_data = BW'(33); s_valid = 1;
      for (int i = 0; i < 200 && !got; i++) begin
        @(negedge clock);
        if (s_ready) got = 1;
      end
      @(posedge clock); #1;
      s_data = BW'(44);
      for (int i = 0; i < 30; i++) begin
        @(negedge clock);
        chk("bp_s_ready", s_ready, 0);
      end
      @(posedge clock); #1;
      m_ready = 1;
      got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
        @(negedge clock);
        if (s_ready) got = 1;
      end
      @(posedge clock); #1;
      s_valid = 0;
      chk("bp_accepts", n_acc - n0, 2);
      wait_drain();
    end

    // Full-scale alternating samples, wraps wp, random output stalls.
    rnd_ready = 1;
    for (int j = 0; j < 40; j++) send((j % 2 == 0) ? -2048 : 2047);
    wait_drain();

    // Random coefficients and samples.
    rnd_ready = 0; @(posedge clock); #1; m_ready = 1;
    for (int j = 0; j < TAPS; j++) wcoef(j, int'($urandom_range(0, 65535)), 1);
    rnd_ready = 1;
    for (int j = 0; j < 30; j++) send(int'($urandom_range(0, 4095)));
    wait_drain();
    rnd_ready = 0; @(posedge clock); #1; m_ready = 1;

    // Asynchronous reset mid-ISSUE abandons the result and clears coefficients.
    send(77);
    repeat (5) @(posedge clock); #1;
    reset = 0;
    exp_q.delete();
    hist.delete();
    front_seen = 0;
    for (int i = 0; i < TAPS; i++) cm[i] = 0;
    repeat (2) @(posedge clock); #1;
    reset = 1;
    @(posedge clock); #1;
    chk("post_rst_m_valid", m_valid, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_s_ready", s_ready, 1);
    send(123);
    wait_drain();
    chk("post_rst_out_count", n_acc > 0, 1);
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
